// File: rtl/dfp_pkg.sv
// rtl/dfp_pkg.sv - shared types and helpers for the BCD significand normalizer
// Purpose: FSM state encoding, BCD digit type, digit-count helper.
// Ports: none (package).
package dfp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  // Significand digit count: three digits per declet plus the leading digit.
  function automatic int dfp_digits(input int n);
    return 3 * n + 1;
  endfunction

endpackage

// File: rtl/dfp_bcd_normalize_if.sv
// rtl/dfp_bcd_normalize_if.sv - operand-in / result-out handshake bundle
// Purpose: groups the input operand and output result handshakes.
// Ports: i_valid/i_ready/i_sign/i_exp/i_sig (operand), o_valid/o_ready/o_sign/o_exp/o_sig/
//        o_lzc/o_zero/o_sub (result). master = producer/consumer side, slave = normalizer.
interface dfp_bcd_normalize_if
  import dfp_pkg::*;
#(
  parameter int N    = 11,
  parameter int EXPW = 14
);
  localparam int D  = dfp_digits(N);
  localparam int LW = $clog2(D + 1);

  logic            i_valid;
  logic            i_ready;
  logic            i_sign;
  logic [EXPW-1:0] i_exp;
  logic [4*D-1:0]  i_sig;
  logic            o_valid;
  logic            o_ready;
  logic            o_sign;
  logic [EXPW-1:0] o_exp;
  logic [4*D-1:0]  o_sig;
  logic [LW-1:0]   o_lzc;
  logic            o_zero;
  logic            o_sub;

  modport master (
    output i_valid, i_sign, i_exp, i_sig, o_ready,
    input  i_ready, o_valid, o_sign, o_exp, o_sig, o_lzc, o_zero, o_sub
  );

  modport slave (
    input  i_valid, i_sign, i_exp, i_sig, o_ready,
    output i_ready, o_valid, o_sign, o_exp, o_sig, o_lzc, o_zero, o_sub
  );

endinterface

// File: rtl/dfp_bcd_lzd.sv
// rtl/dfp_bcd_lzd.sv - leading zero digit count over a STEP-digit window
// Purpose: combinational count of leading zero BCD digits, saturating at STEP.
// Ports: window (in, 4*STEP bits, most significant digit at the top), count (out).
module dfp_bcd_lzd
  import dfp_pkg::*;
#(
  parameter int STEP = 1,
  parameter int KW   = $clog2(STEP + 1)
) (
  input  logic [4*STEP-1:0] window,
  output logic [KW-1:0]     count
);

  bcd_digit_t digit;
  logic       found;

  // Any nonzero nibble stops the count; digits above 9 are not filtered.
  always_comb begin
    count = KW'(STEP);
    found = 1'b0;
    digit = '0;
    for (int i = 0; i < STEP; i++) begin
      digit = window[4*(STEP-1-i) +: 4];
      if (!found && (digit != 4'd0)) begin
        count = KW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dfp_bcd_normalize.sv
// rtl/dfp_bcd_normalize.sv - iterative left-normalizer for decoded BCD significands
// Purpose: shifts out leading zero digits (up to STEP per cycle), decrementing the biased
//          exponent, until the MSD is nonzero or the exponent reaches 0.
// Ports: clk, rst (sync active-high), bus (slave side of dfp_bcd_normalize_if).
module dfp_bcd_normalize
  import dfp_pkg::*;
#(
  parameter int N    = 11,
  parameter int EXPW = 14,
  parameter int STEP = 1
) (
  input  logic               clk,
  input  logic               rst,
  dfp_bcd_normalize_if.slave bus
);

  localparam int D  = dfp_digits(N);
  localparam int SW = 4 * D;
  localparam int LW = $clog2(D + 1);
  localparam int KW = $clog2(STEP + 1);

  state_t          state_q, state_d;
  logic            sign_q, sign_d;
  logic [EXPW-1:0] exp_q, exp_d;
  logic [SW-1:0]   sig_q, sig_d;
  logic [LW-1:0]   lzc_q, lzc_d;
  logic            zero_q, zero_d;
  logic            sub_q, sub_d;
  logic            first_q, first_d;
  logic [KW-1:0]   k_raw;
  logic [KW-1:0]   k;
  logic            accept;

  dfp_bcd_lzd #(.STEP(STEP), .KW(KW)) u_lzd (
    .window (sig_q[SW-1 -: 4*STEP]),
    .count  (k_raw)
  );

  // Never shift more digits than the exponent can absorb.
  assign k = (EXPW'(k_raw) > exp_q) ? KW'(exp_q) : k_raw;

  assign bus.i_ready = (state_q == IDLE) && !rst;
  assign accept      = bus.i_valid && bus.i_ready;

  assign bus.o_valid = (state_q == DONE);
  assign bus.o_sign  = sign_q;
  assign bus.o_exp   = exp_q;
  assign bus.o_sig   = sig_q;
  assign bus.o_lzc   = lzc_q;
  assign bus.o_zero  = zero_q;
  assign bus.o_sub   = sub_q;

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    sig_d   = sig_q;
    lzc_d   = lzc_q;
    zero_d  = zero_q;
    sub_d   = sub_q;
    first_d = first_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          sign_d  = bus.i_sign;
          exp_d   = bus.i_exp;
          sig_d   = bus.i_sig;
          lzc_d   = '0;
          zero_d  = 1'b0;
          sub_d   = 1'b0;
          first_d = 1'b1;
        end
      end
      SHIFT: begin
        first_d = 1'b0;
        // Zero detection only on entry: shifting never removes a nonzero digit.
        if (first_q && (sig_q == '0)) begin
          zero_d  = 1'b1;
          lzc_d   = LW'(D);
          state_d = DONE;
        end else if (k == '0) begin
          sub_d   = (exp_q == '0) && (sig_q[SW-1 -: 4] == 4'd0);
          state_d = DONE;
        end else begin
          sig_d = sig_q << {k, 2'b00};
          exp_d = exp_q - EXPW'(k);
          lzc_d = lzc_q + LW'(k);
        end
      end
      DONE: begin
        if (bus.o_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      sig_q   <= '0;
      lzc_q   <= '0;
      zero_q  <= 1'b0;
      sub_q   <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      sig_q   <= sig_d;
      lzc_q   <= lzc_d;
      zero_q  <= zero_d;
      sub_q   <= sub_d;
      first_q <= first_d;
    end
  end

endmodule

// File: tb/tb_dfp_bcd_normalize.sv
// tb/tb_dfp_bcd_normalize.sv - directed table-driven bench for dfp_bcd_normalize (STEP=1 and STEP=4)
module tb_dfp_bcd_normalize;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  dfp_bcd_normalize_if #(.N(11), .EXPW(14)) bus_a ();
  dfp_bcd_normalize_if #(.N(11), .EXPW(14)) bus_b ();

  dfp_bcd_normalize #(.N(11), .EXPW(14), .STEP(1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  dfp_bcd_normalize #(.N(11), .EXPW(14), .STEP(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  typedef struct {
    logic         sign;
    logic [13:0]  exp;
    logic [135:0] sig;
    logic [13:0]  x_exp;
    logic [135:0] x_sig;
    logic [5:0]   x_lzc;
    logic         x_zero;
    logic         x_sub;
    int           lat1;
    int           lat4;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs [NV];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [135:0] act, input logic [135:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, req);
    end
  endtask

  task automatic chk_res(input string tag, input vec_t v, input logic s, input logic [13:0] e,
                         input logic [135:0] sg, input logic [5:0] l, input logic z,
                         input logic sb);
    chk({tag, "_sign"}, 136'(s), 136'(v.sign));
    chk({tag, "_exp"}, 136'(e), 136'(v.x_exp));
    chk({tag, "_sig"}, sg, v.x_sig);
    chk({tag, "_lzc"}, 136'(l), 136'(v.x_lzc));
    chk({tag, "_zero"}, 136'(z), 136'(v.x_zero));
    chk({tag, "_sub"}, 136'(sb), 136'(v.x_sub));
  endtask

  task automatic drive(input logic s, input logic [13:0] e, input logic [135:0] sg);
    bus_a.i_valid = 1'b1; bus_a.i_sign = s; bus_a.i_exp = e; bus_a.i_sig = sg;
    bus_b.i_valid = 1'b1; bus_b.i_sign = s; bus_b.i_exp = e; bus_b.i_sig = sg;
  endtask

  task automatic idle_inputs();
    bus_a.i_valid = 1'b0;
    bus_b.i_valid = 1'b0;
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    int   lat_a;
    int   lat_b;
    v = vecs[idx];
    @(negedge clk);
    drive(v.sign, v.exp, v.sig);
    chk($sformatf("v%0d_iready_a", idx), 136'(bus_a.i_ready), 136'd1);
    chk($sformatf("v%0d_iready_b", idx), 136'(bus_b.i_ready), 136'd1);
    @(posedge clk);
    #1;
    idle_inputs();
    lat_a = -1;
    lat_b = -1;
    for (int c = 1; c <= 60 && (lat_a < 0 || lat_b < 0); c++) begin
      @(posedge clk);
      #1;
      if (lat_a < 0 && bus_a.o_valid) begin
        lat_a = c;
        chk_res($sformatf("v%0d_a", idx), v, bus_a.o_sign, bus_a.o_exp, bus_a.o_sig,
                bus_a.o_lzc, bus_a.o_zero, bus_a.o_sub);
      end
      if (lat_b < 0 && bus_b.o_valid) begin
        lat_b = c;
        chk_res($sformatf("v%0d_b", idx), v, bus_b.o_sign, bus_b.o_exp, bus_b.o_sig,
                bus_b.o_lzc, bus_b.o_zero, bus_b.o_sub);
      end
    end
    chk($sformatf("v%0d_lat_a", idx), 136'(lat_a), 136'(v.lat1));
    chk($sformatf("v%0d_lat_b", idx), 136'(lat_b), 136'(v.lat4));
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_ovalid_a"}, 136'(bus_a.o_valid), 136'd0);
    chk({tag, "_sign_a"}, 136'(bus_a.o_sign), 136'd0);
    chk({tag, "_exp_a"}, 136'(bus_a.o_exp), 136'd0);
    chk({tag, "_sig_a"}, bus_a.o_sig, 136'd0);
    chk({tag, "_lzc_a"}, 136'(bus_a.o_lzc), 136'd0);
    chk({tag, "_zero_a"}, 136'(bus_a.o_zero), 136'd0);
    chk({tag, "_sub_a"}, 136'(bus_a.o_sub), 136'd0);
    chk({tag, "_ovalid_b"}, 136'(bus_b.o_valid), 136'd0);
    chk({tag, "_exp_b"}, 136'(bus_b.o_exp), 136'd0);
    chk({tag, "_sig_b"}, bus_b.o_sig, 136'd0);
  endtask

  initial begin
    int pulses;
    int waited;

    //          sign  exp      sig                   x_exp    x_sig                        lzc    zero  sub   l1  l4
    vecs[0] = '{1'b0, 14'd6176, 136'h1 << 132,       14'd6176, 136'h1 << 132,              6'd0,  1'b0, 1'b0, 1,  1};
    vecs[1] = '{1'b1, 14'd6176, 136'h123,            14'd6145, 136'h123 << 124,            6'd31, 1'b0, 1'b0, 32, 9};
    vecs[2] = '{1'b0, 14'd10,   136'h5,              14'd0,    136'h5 << 40,               6'd10, 1'b0, 1'b1, 11, 4};
    vecs[3] = '{1'b1, 14'd100,  136'h0,              14'd100,  136'h0,                     6'd34, 1'b1, 1'b0, 1,  1};
    vecs[4] = '{1'b0, 14'd0,    136'h77,             14'd0,    136'h77,                    6'd0,  1'b0, 1'b1, 1,  1};
    vecs[5] = '{1'b1, 14'd2,    136'h9 << 120,       14'd0,    136'h9 << 128,              6'd2,  1'b0, 1'b1, 3,  2};
    vecs[6] = '{1'b0, 14'd50,   136'h45 << 104,      14'd44,   136'h45 << 128,             6'd6,  1'b0, 1'b0, 7,  3};
    vecs[7] = '{1'b1, 14'd5,    136'hA << 128,       14'd4,    136'hA << 132,              6'd1,  1'b0, 1'b0, 2,  2};

    idle_inputs();
    bus_a.i_sign = 1'b0; bus_a.i_exp = '0; bus_a.i_sig = '0;
    bus_b.i_sign = 1'b0; bus_b.i_exp = '0; bus_b.i_sig = '0;
    bus_a.o_ready = 1'b1;
    bus_b.o_ready = 1'b1;

    // Reset state.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_zero_outs("reset");
    chk("reset_iready_in_rst", 136'(bus_a.i_ready), 136'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_iready_after", 136'(bus_a.i_ready), 136'd1);
    chk("reset_iready_after_b", 136'(bus_b.i_ready), 136'd1);

    for (int i = 0; i < NV; i++) begin
      run_vec(i);
    end

    // Backpressure: hold o_ready low for 5 cycles in DONE; new input must be ignored.
    @(negedge clk);
    bus_a.o_ready = 1'b0;
    bus_b.o_ready = 1'b0;
    drive(1'b1, 14'd7, 136'h3 << 132);
    @(posedge clk);
    #1;
    idle_inputs();
    waited = 0;
    while (!(bus_a.o_valid && bus_b.o_valid) && waited < 10) begin
      @(posedge clk);
      #1;
      waited++;
    end
    chk("hold_reach_done", 136'(bus_a.o_valid && bus_b.o_valid), 136'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      drive(1'b0, 14'd3, 136'h5);
      chk($sformatf("hold%0d_ovalid_a", c), 136'(bus_a.o_valid), 136'd1);
      chk($sformatf("hold%0d_ovalid_b", c), 136'(bus_b.o_valid), 136'd1);
      chk($sformatf("hold%0d_exp_a", c), 136'(bus_a.o_exp), 136'd7);
      chk($sformatf("hold%0d_sig_a", c), bus_a.o_sig, 136'h3 << 132);
      chk($sformatf("hold%0d_sign_b", c), 136'(bus_b.o_sign), 136'd1);
      chk($sformatf("hold%0d_iready_a", c), 136'(bus_a.i_ready), 136'd0);
      @(posedge clk);
    end
    @(negedge clk);
    idle_inputs();
    bus_a.o_ready = 1'b1;
    bus_b.o_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release_ovalid_a", 136'(bus_a.o_valid), 136'd0);
    chk("release_iready_a", 136'(bus_a.i_ready), 136'd1);
    chk("release_iready_b", 136'(bus_b.i_ready), 136'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("release_no_ghost_a", 136'(bus_a.o_valid), 136'd0);
    chk("release_no_ghost_b", 136'(bus_b.o_valid), 136'd0);

    // Reset during a long SHIFT aborts without a result.
    @(negedge clk);
    drive(1'b1, 14'd6176, 136'h123);
    @(posedge clk);
    #1;
    idle_inputs();
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("abort_busy_a", 136'(bus_a.i_ready), 136'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_zero_outs("abort");
    chk("abort_iready_in_rst", 136'(bus_b.i_ready), 136'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_iready_a", 136'(bus_a.i_ready), 136'd1);
    chk("abort_iready_b", 136'(bus_b.i_ready), 136'd1);
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (bus_a.o_valid || bus_b.o_valid) pulses++;
    end
    chk("abort_no_ovalid", 136'(pulses), 136'd0);

    // Still usable after the abort.
    run_vec(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
